// File: rtl/demux_rr_sched.sv
// Round-robin scheduler sharing one serial source among eight lanes.
// Bounded bursts per grant, registered one-hot demux output with strobe.
module demux_rr_sched #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       d,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [2:0] s,
    output logic [7:0] gnt,
    output logic [7:0] y,
    output logic [7:0] y_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t             state;
    logic [2:0]         last;
    logic [CNT_W-1:0]   beat_cnt;

    logic [2:0]         start;
    logic [15:0]        req_dbl;
    logic [7:0]         req_rot;
    logic [2:0]         offset;
    logic               found;
    logic [2:0]         pick;
    logic               last_beat;

    // Rotate so bit 0 is the lane after the one last served.
    always_comb begin
        start   = last + 3'd1;
        req_dbl = {req, req} >> start;
        req_rot = req_dbl[7:0];
        offset  = 3'd0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req_rot[i]) begin
                offset = 3'(i);
                found  = 1'b1;
            end
        end
        pick = start + offset;
    end

    assign src_ready = (state == XFER) & req[s];
    assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 3'd7;
            beat_cnt <= '0;
            s        <= 3'd0;
            gnt      <= 8'h00;
            y        <= 8'h00;
            y_valid  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    y_valid <= 8'h00;
                    if (|req) begin
                        s        <= pick;
                        gnt      <= 8'h01 << pick;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!req[s]) begin
                        y_valid <= 8'h00;
                        last    <= s;
                        gnt     <= 8'h00;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (src_valid) begin
                        y        <= {7'b0, d} << s;
                        y_valid  <= 8'h01 << s;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            last  <= s;
                            gnt   <= 8'h00;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        y_valid <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demux_rr_sched.sv
// Bench for demux_rr_sched: burst-4 and burst-1 instances vs a lane-level model.
// Directed scenarios first, then randomized traffic with async resets.
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       d = 1'b0;
    logic       src_valid = 1'b0;

    logic       rdy[2];
    logic [2:0] s_o[2];
    logic [7:0] gnt_o[2];
    logic [7:0] y_o[2];
    logic [7:0] yv_o[2];
    logic       busy_o[2];

    int n_chk = 0;
    int n_pass = 0;

    // model: granted lane (-1 = idle), beats done, lane last served
    int         mb[2] = '{4, 1};
    int         g[2];
    int         cnt[2];
    int         lst[2];
    logic [2:0] ms[2];
    logic [7:0] my[2];
    logic [7:0] myv[2];

    always #5 clk = ~clk;

    demux_rr_sched #(.MAX_BURST(4), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
        .src_valid(src_valid), .src_ready(rdy[0]), .s(s_o[0]),
        .gnt(gnt_o[0]), .y(y_o[0]), .y_valid(yv_o[0]), .busy(busy_o[0])
    );

    demux_rr_sched #(.MAX_BURST(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
        .src_valid(src_valid), .src_ready(rdy[1]), .s(s_o[1]),
        .gnt(gnt_o[1]), .y(y_o[1]), .y_valid(yv_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            g[i] = -1; cnt[i] = 0; lst[i] = 7;
            ms[i] = 3'd0; my[i] = 8'h00; myv[i] = 8'h00;
        end
    endtask

    task automatic model_next(input int i, input logic [7:0] r,
                              input logic v, input logic dd);
        if (g[i] < 0) begin
            myv[i] = 8'h00;
            for (int k = 1; k <= 8; k++) begin
                if (g[i] < 0 && r[(lst[i] + k) % 8]) begin
                    g[i] = (lst[i] + k) % 8;
                    ms[i] = 3'(g[i]);
                    cnt[i] = 0;
                end
            end
        end else if (!r[g[i]]) begin
            myv[i] = 8'h00; lst[i] = g[i]; g[i] = -1;
        end else if (v) begin
            my[i] = 8'h00;
            my[i][g[i]] = dd;
            myv[i] = 8'h00;
            myv[i][g[i]] = 1'b1;
            cnt[i]++;
            if (cnt[i] == mb[i]) begin
                lst[i] = g[i]; g[i] = -1;
            end
        end else begin
            myv[i] = 8'h00;
        end
    endtask

    task automatic check_outs();
        logic [7:0] eg;
        for (int i = 0; i < 2; i++) begin
            eg = (g[i] >= 0) ? (8'h01 << g[i]) : 8'h00;
            chk($sformatf("s%0d", i), s_o[i], ms[i]);
            chk($sformatf("gnt%0d", i), gnt_o[i], eg);
            chk($sformatf("y%0d", i), y_o[i], my[i]);
            chk($sformatf("y_valid%0d", i), yv_o[i], myv[i]);
            chk($sformatf("busy%0d", i), busy_o[i], g[i] >= 0);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic v, input logic dd);
        @(negedge clk);
        req = r; src_valid = v; d = dd;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("src_ready%0d", i), rdy[i],
                (g[i] >= 0) && r[g[i]]);
            model_next(i, r, v, dd);
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    // Reset lands between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        for (int i = 0; i < 2; i++)
            chk($sformatf("rst_ready%0d", i), rdy[i], 1'b0);
        req = 8'h00; src_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        logic       v;
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_outs();
        #1 rst_n = 1'b1;

        for (int k = 0; k < 12; k++) step(8'h04, 1'b1, ~k[0]);

        for (int k = 0; k < 60; k++) step(8'hFF, 1'b1, 1'($urandom));

        for (int k = 0; k < 20 && g[0] != 0; k++) step(8'h21, 1'b1, 1'b1);
        step(8'h21, 1'b1, 1'b1);
        step(8'h21, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) step(8'h20, 1'b1, 1'b1);

        for (int k = 0; k < 20 && g[0] != 3; k++) step(8'h08, 1'b0, 1'b0);
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            for (int k = 6; k >= 0; k--) step(8'h08, pat[k], 1'($urandom));
        end
        for (int k = 0; k < 4; k++) step(8'h08, 1'b1, 1'b1);

        for (int k = 0; k < 20 && g[0] != 6; k++) step(8'h40, 1'b0, 1'b0);
        step(8'h40, 1'b1, 1'b1);
        step(8'h40, 1'b1, 1'b1);
        async_reset();
        for (int k = 0; k < 10; k++) step(8'hC0, 1'b1, 1'($urandom));

        for (int k = 0; k < 10; k++) step(8'h11, 1'b1, 1'($urandom));

        r = 8'($urandom);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 1'($urandom));
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
Round-robin scheduler that shares one 1-bit serial source among 8 destinations through a 1-to-8 demultiplex path. Destinations raise a request. The block grants one destination at a time for a bounded burst, drives the 3-bit select, and handshakes beats from the source. Accepted bits appear registered on the granted output lane with a one-cycle valid strobe. It sits between a single serial producer and eight consumer lanes.

Parameters:
MAX_BURST, 4, maximum beats per grant; legal range 1..16
CNT_W, 4, beat counter width; must satisfy 2**CNT_W >= MAX_BURST

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  per-destination request; bit i = lane i wants data
d  input  1  serial source data bit
src_valid  input  1  source has a valid bit on d
src_ready  output  1  scheduler accepts d this cycle (combinational)
s  output  3  registered select of the current/last granted lane
gnt  output  8  registered one-hot grant; zero when idle
y  output  8  registered demux output; only bit s carries data, others 0
y_valid  output  8  one-cycle one-hot strobe marking the lane written in y
busy  output  1  high while in XFER

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: s=0, gnt=0, y=8'h00, y_valid=8'h00, busy=0, src_ready=0, state=IDLE, beat_cnt=0, last=3'd7.
- Because last resets to 7, the first arbitration searches from lane 0.
- FSM states: IDLE, XFER.
- IDLE:
  - gnt=0, busy=0, src_ready=0.
  - If req!=0, pick the first set bit searching (last+1) mod 8 upward with wrap.
  - Next edge: s<=pick, gnt<=onehot(pick), beat_cnt<=0, state<=XFER.
  - Arbitration latency is one cycle from req to gnt.
- XFER:
  - busy=1.
  - src_ready = (state==XFER) & req[s], combinational.
  - A beat is accepted when src_valid & src_ready.
  - On a beat: y<=8'h00 with y[s]<=d, y_valid<=onehot(s), beat_cnt<=beat_cnt+1.
  - No beat in a cycle: y_valid<=0. y holds its previous value.
  - Burst end by count: a beat with beat_cnt==MAX_BURST-1 sends the FSM to IDLE, last<=s, gnt<=0.
  - Burst end by request drop: req[s]==0 in XFER ends the burst. No beat is accepted that cycle; FSM goes to IDLE, last<=s, gnt<=0.
- Handshake and output rules:
  - src_valid low inside XFER is a stall. The grant is held, with no timeout.
  - Data latency from the beat edge to y/y_valid is one cycle.
  - s holds its value in IDLE. It updates only on a grant.
  - There is always one IDLE cycle between consecutive grants. Throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness:
  - The lane just served becomes lowest priority.
  - A lone requester is re-granted after one IDLE cycle.
  - Requests from non-granted lanes are ignored during XFER and do not preempt the grant.
- Reset mid-burst: all outputs return to reset values immediately, independent of clk. The partial burst is discarded and arbitration restarts from lane 0.
- MAX_BURST=1: every accepted beat ends the grant.

Test Plan:
1. Reset, req=8'h04, src_valid=1, d alternating 1,0,1,0 -> gnt=8'h04 and s=2 one cycle after req. Four beats; y_valid=8'h04 each cycle; y = 8'h04, 00, 04, 00. Then IDLE for 1 cycle, then re-grant lane 2.
2. req=8'hFF held, src_valid=1 -> grants in order lanes 0,1,2,...,7,0. Each grant lasts 4 beats plus 1 idle cycle. y_valid never has two bits set.
3. req=8'h21, lane 0 granted; drop req[0] after 2 beats -> src_ready falls in the same cycle with no third beat. IDLE next, then lane 5 granted.
4. Lane 3 granted, src_valid toggles 1,0,0,1,1,0,1 -> exactly 4 beats accepted. gnt stays 8'h08 through the stalls. y_valid pulses only on accept+1 cycles.
5. rst_n asserted low mid-burst (after 2 beats on lane 6), asynchronous to clk -> gnt, y, y_valid and busy go to 0 immediately. After release with req=8'hC0, lane 6 is granted first, because the search starts from 0 and lane 6 is the first set bit.
6. MAX_BURST=1, req=8'h11 -> grants alternate lane 0 and lane 4. Each grant carries one beat, and there is one idle cycle between grants.
